// File: rtl/spi_baud_scheduler.sv
// Round-robin scheduler sharing one baud-rate divider between two SPI channels.
// Grants a channel, loads its divide value, and counts divider edges to frame a transfer.
module spi_baud_scheduler #(
  parameter int LEN_W = 5,
  parameter int NW    = 32
) (
  input  logic              SOURCE_CLK,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [NW-1:0]     n0,
  input  logic [NW-1:0]     n1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  input  logic              div_nout,
  output logic              div_enable,
  output logic              div_reset,
  output logic [NW-1:0]     div_n,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic              aborted,
  output logic              busy,
  output logic              sclk_rise,
  output logic              sclk_fall,
  output logic [LEN_W:0]    bit_idx
);

  localparam int CNT_W = LEN_W + 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic             win;
  logic             last;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_next;
  logic             nout_q;
  logic             pick;
  logic             abort;
  logic             active;
  logic             edge_hit;

  // Two divider edges per bit; a zero length encodes the full 2^LEN_W-bit frame.
  function automatic logic [CNT_W-1:0] frame_edges(input logic [LEN_W-1:0] len);
    if (len == '0) frame_edges = CNT_W'(1) << (LEN_W + 1);
    else           frame_edges = {1'b0, len, 1'b0};
  endfunction

  always_comb begin
    pick       = (req == 2'b11) ? ~last : req[1];
    active     = (state == LOAD) || (state == RUN);
    abort      = active && !req[win];
    sclk_rise  = (state == RUN) && !abort && div_nout && !nout_q;
    sclk_fall  = (state == RUN) && !abort && !div_nout && nout_q;
    edge_next  = edge_cnt + CNT_W'(1);
    edge_hit   = (sclk_rise || sclk_fall) && (edge_next == frame_edges(len_q));
    // Reset also drives the divider's own clear so the gated-clock block comes up clean.
    div_enable = reset || (active && !abort);
    div_reset  = reset || (state == LOAD);
    done       = (state == DONE) ? gnt : 2'b00;
    aborted    = abort;
    busy       = (state != IDLE);
  end

  always_ff @(posedge SOURCE_CLK) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      win      <= 1'b0;
      last     <= 1'b1;
      div_n    <= '0;
      edge_cnt <= '0;
      bit_idx  <= '0;
      nout_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= pick;
            gnt   <= pick ? 2'b10 : 2'b01;
            div_n <= pick ? n1 : n0;
            state <= LOAD;
          end
        end
        LOAD: begin
          edge_cnt <= '0;
          bit_idx  <= '0;
          nout_q   <= 1'b0;
          last     <= win;
          if (abort) begin
            gnt   <= 2'b00;
            state <= IDLE;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            gnt   <= 2'b00;
            state <= IDLE;
          end else begin
            nout_q <= div_nout;
            if (sclk_rise || sclk_fall) edge_cnt <= edge_next;
            if (sclk_fall)              bit_idx  <= bit_idx + 1'b1;
            if (edge_hit)               state    <= DONE;
          end
        end
        default: begin
          gnt   <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge SOURCE_CLK) begin
    if (state == IDLE && |req) len_q <= pick ? len1 : len0;
  end

endmodule

// File: doc/spi_baud_scheduler.md
Name: spi_baud_scheduler

Overview:
Controller that shares one baudratedivider instance between two SPI channel requesters.
It arbitrates requests round-robin, loads the winner's divide value into the divider, and enables and resets the divider.
It counts divider output edges to frame a transfer of a requested bit length, then signals completion to the granted channel.
It sits between the per-channel SPI shift engines and the single baud generator in the gpio/SPI module.

Parameters:
LEN_W, 5, width of frame-length inputs; value 0 means 2^LEN_W bits (32).
NW, 32, width of divide value (fixed-point, 7 fractional bits, passed through unmodified).

Ports:
SOURCE_CLK  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  2  per-channel transfer request, level; held until done or abort
n0  in  NW  channel 0 divide value
n1  in  NW  channel 1 divide value
len0  in  LEN_W  channel 0 frame length in bits
len1  in  LEN_W  channel 1 frame length in bits
div_nout  in  1  Nout from shared divider
div_enable  out  1  divider enable
div_reset  out  1  divider reset
div_n  out  NW  divide value presented to divider
gnt  out  2  one-hot grant
done  out  2  one-cycle completion pulse per channel
aborted  out  1  one-cycle pulse, transfer dropped
busy  out  1  high in any state except IDLE
sclk_rise  out  1  one-cycle pulse on rising edge of div_nout while in RUN
sclk_fall  out  1  one-cycle pulse on falling edge of div_nout while in RUN
bit_idx  out  LEN_W+1  completed bits in current frame

Behaviour:
- Reset (SOURCE_CLK edge with reset=1): state IDLE; gnt=0, done=0, aborted=0, busy=0, bit_idx=0, div_n=0; rr pointer favours ch0.
- While reset=1, drive div_enable=1 and div_reset=1 so the gated-clock divider is also cleared. Both deassert the cycle after reset falls.
- States: IDLE -> LOAD -> RUN -> DONE -> IDLE.
- IDLE:
  - div_enable=0, div_reset=0.
  - If any req bit is set, pick the winner: a lone requester wins; if both request, the channel not granted last wins.
  - Register gnt, div_n=n_winner, and len_winner.
  - Go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - div_enable=1, div_reset=1, which loads target=N and sets Nout=0 in the divider.
  - Clear edge counter, bit_idx, and the div_nout history register (nout_q=0).
  - Update rr pointer to the winner.
- RUN:
  - div_enable=1, div_reset=0.
  - rise = div_nout & ~nout_q; fall = ~div_nout & nout_q. Each is a registered-free combinational pulse, gated by state==RUN.
  - Edge counter (LEN_W+2 bits) increments on each edge.
  - bit_idx increments on each fall.
  - When the counter reaches 2*len, where len=0 means 32, go to DONE in the same cycle as that final edge.
- DONE (1 cycle):
  - done[winner]=1, div_enable=0.
  - gnt is held through DONE and cleared on entry to IDLE.
- Abort: if req[winner]=0 in LOAD or RUN, pulse aborted, clear gnt, div_enable=0, go to IDLE. No done is issued.
- Timing: a req arriving during DONE is evaluated only in the following IDLE, so there is at least one IDLE cycle between transfers.
- div_n and the latched length are constant from LOAD to DONE. Changes to n0/n1/len0/len1 mid-transfer are ignored.
- Simultaneous req edge and reset: reset wins.
- A winner rule change never preempts a running transfer.

Test Plan:
- Reset with req=2'b11 held -> while reset=1, div_enable=1, div_reset=1, gnt=0; first grant after release is gnt=2'b01.
- req0 only, n0=0x100 (÷2.0), len0=4:
  - gnt=01 one cycle after req.
  - LOAD 1 cycle, div_n=0x100.
  - Exactly 4 sclk_rise and 4 sclk_fall.
  - done[0] pulses on the cycle after the 8th div_nout edge; bit_idx=4.
- Both requesting continuously, len=2 each -> grants alternate 01, 10, 01, with one idle cycle between each done and the next LOAD.
- len1=0 with req1 -> 64 edges counted before done[1]; bit_idx=32.
- Drop req0 mid-RUN after 3 edges -> aborted pulses, gnt=0, div_enable=0, no done; a pending req1 is granted next IDLE.
- Assert reset during RUN -> next cycle state IDLE, busy=0, bit_idx=0, div_reset=1 while reset is held.
